// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: 6-bit sqN, flush FSM states and
// age arithmetic relative to the oldest in-flight instruction.
package branch_resolver_pkg;

    localparam int SQN_W = 6;

    typedef logic [SQN_W-1:0] sqn_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    // Distance from the commit pointer; the modulo-64 wrap falls out of 6-bit subtraction.
    function automatic sqn_t sqn_age(input sqn_t sqn, input sqn_t base);
        return sqn - base;
    endfunction

    function automatic logic sqn_older(input sqn_t a, input sqn_t b, input sqn_t base);
        return (sqn_age(a, base) < sqn_age(b, base));
    endfunction

endpackage

// File: rtl/branch_select_oldest.sv
// Combinational oldest-of-N picker over candidate branch results;
// equal ages resolve to the lowest port index.
module branch_select_oldest
    import branch_resolver_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0]  cand,
    input  sqn_t [NUM_PORTS-1:0]  sqn,
    input  sqn_t                  base,
    output logic                  found,
    output logic [IDX_W-1:0]      idx
);

    sqn_t best_age_s;

    // Linear scan; strict less-than keeps the earlier port on ties.
    always_comb begin
        found      = 1'b0;
        idx        = '0;
        best_age_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (cand[i] && (!found || (sqn_age(sqn[i], base) < best_age_s))) begin
                found      = 1'b1;
                idx        = IDX_W'(i);
                best_age_s = sqn_age(sqn[i], base);
            end else begin
                best_age_s = best_age_s;
            end
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Oldest-taken-branch redirect generator with a timed flush window.
// Optional statistics counters enabled by defining BRANCH_RESOLVER_STATS_EN.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int NUM_PORTS    = 2,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_PORTS-1:0]        IN_valid,
    input  logic [NUM_PORTS-1:0]        IN_isBranch,
    input  logic [NUM_PORTS-1:0]        IN_branchTaken,
    input  logic [NUM_PORTS-1:0][31:0]  IN_branchAddress,
    input  logic [NUM_PORTS-1:0][5:0]   IN_branchSqN,
    input  logic [5:0]                  IN_commitSqN,
    output logic                        OUT_redirect,
    output logic [31:0]                 OUT_redirectAddr,
    output logic [5:0]                  OUT_redirectSqN,
    output logic                        OUT_flushActive,
    output logic [5:0]                  OUT_flushSqN
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [31:0]                 OUT_statBranches,
    output logic [31:0]                 OUT_statRedirects
`endif
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);

    flush_state_e          state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  redirect_r, redirect_s;
    logic [31:0]           addr_r, addr_s;
    sqn_t                  sqn_r, sqn_s;
    sqn_t                  flush_sqn_r, flush_sqn_s;
    logic [NUM_PORTS-1:0]  cand_s;
    logic                  sel_found_s;
    logic [IDX_W-1:0]      sel_idx_s;

    // During a flush only results strictly older than the flush bound may compete.
    always_comb begin
        cand_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (IN_valid[i] && IN_isBranch[i] && IN_branchTaken[i]) begin
                cand_s[i] = (state_r == ST_IDLE) ||
                            sqn_older(IN_branchSqN[i], flush_sqn_r, IN_commitSqN);
            end else begin
                cand_s[i] = 1'b0;
            end
        end
    end

    branch_select_oldest #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_select (
        .cand  (cand_s),
        .sqn   (IN_branchSqN),
        .base  (IN_commitSqN),
        .found (sel_found_s),
        .idx   (sel_idx_s)
    );

    // Next-state and next-output logic for the flush window FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        redirect_s  = 1'b0;
        addr_s      = addr_r;
        sqn_s       = sqn_r;
        flush_sqn_s = flush_sqn_r;
        if (sel_found_s) begin
            state_s     = ST_FLUSH;
            cnt_s       = CNT_LOAD;
            redirect_s  = 1'b1;
            addr_s      = IN_branchAddress[sel_idx_s];
            sqn_s       = IN_branchSqN[sel_idx_s];
            flush_sqn_s = IN_branchSqN[sel_idx_s];
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_FLUSH: begin
                    if (cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_s = ST_IDLE;
                        cnt_s   = '0;
                    end else begin
                        cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // State and output registers; a disabled cycle only retires the redirect pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            redirect_r  <= 1'b0;
            addr_r      <= '0;
            sqn_r       <= '0;
            flush_sqn_r <= '0;
        end else if (en) begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            redirect_r  <= redirect_s;
            addr_r      <= addr_s;
            sqn_r       <= sqn_s;
            flush_sqn_r <= flush_sqn_s;
        end else begin
            redirect_r  <= 1'b0;
        end
    end

    assign OUT_redirect     = redirect_r;
    assign OUT_redirectAddr = addr_r;
    assign OUT_redirectSqN  = sqn_r;
    assign OUT_flushActive  = (state_r == ST_FLUSH);
    assign OUT_flushSqN     = flush_sqn_r;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] branch_cnt_s;

    // Every valid branch counts, including ones dropped by the flush window.
    always_comb begin
        branch_cnt_s = 32'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            branch_cnt_s = branch_cnt_s + 32'(IN_valid[i] & IN_isBranch[i]);
        end
    end

    // Free-running statistics counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            OUT_statBranches  <= 32'd0;
            OUT_statRedirects <= 32'd0;
        end else if (en) begin
            OUT_statBranches  <= OUT_statBranches + branch_cnt_s;
            OUT_statRedirects <= OUT_statRedirects + 32'(sel_found_s);
        end else begin
            OUT_statBranches  <= OUT_statBranches;
            OUT_statRedirects <= OUT_statRedirects;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (NUM_PORTS=2, FLUSH_CYCLES=3);
// define BRANCH_RESOLVER_STATS_EN to also exercise the statistics counters.
module tb_branch_resolver;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       valid;
    logic [1:0]       is_branch;
    logic [1:0]       taken;
    logic [1:0][31:0] baddr;
    logic [1:0][5:0]  bsqn;
    logic [5:0]       commit_sqn;
    logic             redirect;
    logic [31:0]      redirect_addr;
    logic [5:0]       redirect_sqn;
    logic             flush_active;
    logic [5:0]       flush_sqn;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0]      stat_branches;
    logic [31:0]      stat_redirects;
`endif

    int nvec = 0;
    int nerr = 0;

    branch_resolver #(
        .NUM_PORTS    (2),
        .FLUSH_CYCLES (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .IN_valid         (valid),
        .IN_isBranch      (is_branch),
        .IN_branchTaken   (taken),
        .IN_branchAddress (baddr),
        .IN_branchSqN     (bsqn),
        .IN_commitSqN     (commit_sqn),
        .OUT_redirect     (redirect),
        .OUT_redirectAddr (redirect_addr),
        .OUT_redirectSqN  (redirect_sqn),
        .OUT_flushActive  (flush_active),
        .OUT_flushSqN     (flush_sqn)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .OUT_statBranches  (stat_branches),
        .OUT_statRedirects (stat_redirects)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ports();
        valid     = 2'b00;
        is_branch = 2'b00;
        taken     = 2'b00;
        baddr     = '0;
        bsqn      = '0;
    endtask

    task automatic set_port(input int p, input logic t, input logic [31:0] a, input logic [5:0] s);
        valid[p]     = 1'b1;
        is_branch[p] = 1'b1;
        taken[p]     = t;
        baddr[p]     = a;
        bsqn[p]      = s;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; commit_sqn = 6'd0;
        clear_ports();
        cycle(); cycle();
        rst = 1'b0;
        nvec++; if (redirect !== 1'b0) begin nerr++; $display("FAIL reset_redirect got %0b want 0", redirect); end
        nvec++; if (redirect_addr !== 32'h0) begin nerr++; $display("FAIL reset_addr got %h want 0", redirect_addr); end
        nvec++; if (redirect_sqn !== 6'd0) begin nerr++; $display("FAIL reset_sqn got %0d want 0", redirect_sqn); end
        nvec++; if (flush_active !== 1'b0) begin nerr++; $display("FAIL reset_flush got %0b want 0", flush_active); end
        nvec++; if (flush_sqn !== 6'd0) begin nerr++; $display("FAIL reset_flushsqn got %0d want 0", flush_sqn); end
`ifdef BRANCH_RESOLVER_STATS_EN
        nvec++; if (stat_branches !== 32'd0) begin nerr++; $display("FAIL reset_statb got %0d want 0", stat_branches); end
        nvec++; if (stat_redirects !== 32'd0) begin nerr++; $display("FAIL reset_statr got %0d want 0", stat_redirects); end
`endif
    endtask

    task automatic test_single();
        commit_sqn = 6'd0;
        set_port(0, 1'b1, 32'h0000_1000, 6'd5);
        cycle();
        clear_ports();
        nvec++; if (redirect !== 1'b1) begin nerr++; $display("FAIL single_redirect got %0b want 1", redirect); end
        nvec++; if (redirect_addr !== 32'h0000_1000) begin nerr++; $display("FAIL single_addr got %h want 00001000", redirect_addr); end
        nvec++; if (redirect_sqn !== 6'd5) begin nerr++; $display("FAIL single_sqn got %0d want 5", redirect_sqn); end
        nvec++; if (flush_active !== 1'b1) begin nerr++; $display("FAIL single_flush1 got %0b want 1", flush_active); end
        nvec++; if (flush_sqn !== 6'd5) begin nerr++; $display("FAIL single_flushsqn got %0d want 5", flush_sqn); end
        cycle();
        nvec++; if (redirect !== 1'b0) begin nerr++; $display("FAIL single_pulse got %0b want 0", redirect); end
        nvec++; if (flush_active !== 1'b1) begin nerr++; $display("FAIL single_flush2 got %0b want 1", flush_active); end
        nvec++; if (redirect_addr !== 32'h0000_1000) begin nerr++; $display("FAIL single_hold got %h want 00001000", redirect_addr); end
        cycle();
        nvec++; if (flush_active !== 1'b1) begin nerr++; $display("FAIL single_flush3 got %0b want 1", flush_active); end
        cycle();
        nvec++; if (flush_active !== 1'b0) begin nerr++; $display("FAIL single_idle got %0b want 0", flush_active); end
    endtask

    task automatic test_not_taken();
        commit_sqn = 6'd0;
        set_port(0, 1'b0, 32'h0000_AAAA, 6'd3);
        set_port(1, 1'b0, 32'h0000_BBBB, 6'd4);
        cycle();
        clear_ports();
        nvec++; if (redirect !== 1'b0) begin nerr++; $display("FAIL nottaken_redirect got %0b want 0", redirect); end
        nvec++; if (flush_active !== 1'b0) begin nerr++; $display("FAIL nottaken_flush got %0b want 0", flush_active); end
    endtask

    task automatic test_oldest();
        commit_sqn = 6'd2;
        set_port(0, 1'b1, 32'h0000_0900, 6'd9);
        set_port(1, 1'b1, 32'h0000_0400, 6'd4);
        cycle();
        clear_ports();
        nvec++; if (redirect !== 1'b1) begin nerr++; $display("FAIL oldest_redirect got %0b want 1", redirect); end
        nvec++; if (redirect_sqn !== 6'd4) begin nerr++; $display("FAIL oldest_sqn got %0d want 4", redirect_sqn); end
        nvec++; if (redirect_addr !== 32'h0000_0400) begin nerr++; $display("FAIL oldest_addr got %h want 00000400", redirect_addr); end
        cycle(); cycle(); cycle();
        nvec++; if (flush_active !== 1'b0) begin nerr++; $display("FAIL oldest_drain got %0b want 0", flush_active); end
    endtask

    task automatic test_wrap();
        commit_sqn = 6'd60;
        set_port(0, 1'b1, 32'h0000_0002, 6'd2);
        set_port(1, 1'b1, 32'h0000_003E, 6'd62);
        cycle();
        clear_ports();
        nvec++; if (redirect_sqn !== 6'd62) begin nerr++; $display("FAIL wrap_sqn got %0d want 62", redirect_sqn); end
        nvec++; if (redirect_addr !== 32'h0000_003E) begin nerr++; $display("FAIL wrap_addr got %h want 0000003e", redirect_addr); end
        cycle(); cycle(); cycle();
        nvec++; if (flush_active !== 1'b0) begin nerr++; $display("FAIL wrap_drain got %0b want 0", flush_active); end
    endtask

    task automatic test_tie();
        commit_sqn = 6'd0;
        set_port(0, 1'b1, 32'h0000_0A00, 6'd8);
        set_port(1, 1'b1, 32'h0000_0B00, 6'd8);
        cycle();
        clear_ports();
        nvec++; if (redirect_addr !== 32'h0000_0A00) begin nerr++; $display("FAIL tie_addr got %h want 00000a00", redirect_addr); end
        cycle(); cycle(); cycle();
        nvec++; if (flush_active !== 1'b0) begin nerr++; $display("FAIL tie_drain got %0b want 0", flush_active); end
    endtask

    task automatic test_flush_window();
        commit_sqn = 6'd0;
        set_port(0, 1'b1, 32'h0000_2000, 6'd10);
        cycle();
        clear_ports();
        nvec++; if (flush_sqn !== 6'd10) begin nerr++; $display("FAIL win_flushsqn got %0d want 10", flush_sqn); end
        set_port(1, 1'b1, 32'h0000_2C00, 6'd12);
        cycle();
        clear_ports();
        nvec++; if (redirect !== 1'b0) begin nerr++; $display("FAIL win_drop_young got %0b want 0", redirect); end
        nvec++; if (redirect_addr !== 32'h0000_2000) begin nerr++; $display("FAIL win_drop_addr got %h want 00002000", redirect_addr); end
        set_port(0, 1'b1, 32'h0000_3000, 6'd7);
        cycle();
        clear_ports();
        nvec++; if (redirect !== 1'b1) begin nerr++; $display("FAIL win_override got %0b want 1", redirect); end
        nvec++; if (redirect_sqn !== 6'd7) begin nerr++; $display("FAIL win_override_sqn got %0d want 7", redirect_sqn); end
        nvec++; if (flush_sqn !== 6'd7) begin nerr++; $display("FAIL win_override_flushsqn got %0d want 7", flush_sqn); end
        set_port(1, 1'b1, 32'h0000_7777, 6'd7);
        cycle();
        clear_ports();
        nvec++; if (redirect !== 1'b0) begin nerr++; $display("FAIL win_drop_equal got %0b want 0", redirect); end
        nvec++; if (flush_active !== 1'b1) begin nerr++; $display("FAIL win_reload_a got %0b want 1", flush_active); end
        cycle();
        nvec++; if (flush_active !== 1'b1) begin nerr++; $display("FAIL win_reload_b got %0b want 1", flush_active); end
        cycle();
        nvec++; if (flush_active !== 1'b0) begin nerr++; $display("FAIL win_reload_end got %0b want 0", flush_active); end
    endtask

    task automatic test_enable();
        commit_sqn = 6'd0;
        en = 1'b0;
        set_port(0, 1'b1, 32'h0000_4000, 6'd5);
        for (int k = 0; k < 2; k++) begin
            cycle();
            nvec++; if (redirect !== 1'b0) begin nerr++; $display("FAIL en_low_redirect%0d got %0b want 0", k, redirect); end
            nvec++; if (flush_active !== 1'b0) begin nerr++; $display("FAIL en_low_flush%0d got %0b want 0", k, flush_active); end
        end
        en = 1'b1;
        cycle();
        clear_ports();
        nvec++; if (redirect_addr !== 32'h0000_4000) begin nerr++; $display("FAIL en_high_addr got %h want 00004000", redirect_addr); end
        en = 1'b0;
        cycle();
        nvec++; if (redirect !== 1'b0) begin nerr++; $display("FAIL en_pulse_drop got %0b want 0", redirect); end
        nvec++; if (redirect_addr !== 32'h0000_4000) begin nerr++; $display("FAIL en_addr_hold got %h want 00004000", redirect_addr); end
        cycle();
        en = 1'b1;
        cycle(); cycle();
        nvec++; if (flush_active !== 1'b1) begin nerr++; $display("FAIL en_frozen_cnt got %0b want 1", flush_active); end
        cycle();
        nvec++; if (flush_active !== 1'b0) begin nerr++; $display("FAIL en_resume_end got %0b want 0", flush_active); end
    endtask

    task automatic test_back_to_back();
        commit_sqn = 6'd0;
        set_port(0, 1'b1, 32'h0000_5000, 6'd20);
        cycle();
        set_port(0, 1'b1, 32'h0000_6000, 6'd15);
        cycle();
        clear_ports();
        nvec++; if (redirect !== 1'b1) begin nerr++; $display("FAIL b2b_redirect got %0b want 1", redirect); end
        nvec++; if (redirect_sqn !== 6'd15) begin nerr++; $display("FAIL b2b_sqn got %0d want 15", redirect_sqn); end
    endtask

    task automatic test_reset_mid_flush();
        rst = 1'b1; en = 1'b0;
        cycle();
        rst = 1'b0; en = 1'b1;
        nvec++; if (flush_active !== 1'b0) begin nerr++; $display("FAIL rstmid_flush got %0b want 0", flush_active); end
        nvec++; if (redirect !== 1'b0) begin nerr++; $display("FAIL rstmid_redirect got %0b want 0", redirect); end
        nvec++; if (redirect_addr !== 32'h0) begin nerr++; $display("FAIL rstmid_addr got %h want 0", redirect_addr); end
        nvec++; if (flush_sqn !== 6'd0) begin nerr++; $display("FAIL rstmid_flushsqn got %0d want 0", flush_sqn); end
    endtask

`ifdef BRANCH_RESOLVER_STATS_EN
    task automatic test_stats();
        rst = 1'b1; cycle(); rst = 1'b0;
        commit_sqn = 6'd0;
        set_port(0, 1'b1, 32'h0000_0100, 6'd3);
        set_port(1, 1'b0, 32'h0000_0200, 6'd4);
        cycle();
        taken = 2'b00;
        cycle(); cycle();
        clear_ports();
        nvec++; if (stat_branches !== 32'd6) begin nerr++; $display("FAIL stat_branches got %0d want 6", stat_branches); end
        nvec++; if (stat_redirects !== 32'd1) begin nerr++; $display("FAIL stat_redirects got %0d want 1", stat_redirects); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_not_taken();
        test_oldest();
        test_wrap();
        test_tie();
        test_flush_window();
        test_enable();
        test_back_to_back();
        test_reset_mid_flush();
`ifdef BRANCH_RESOLVER_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Collects branch outcomes from the integer ALU ports, selects the oldest taken branch each cycle, and issues a single registered redirect (target address + sqN) to the fetch frontend. Sits between the ALUs' branch outputs and the frontend/ROB flush logic. Tracks an in-progress flush window so that younger branch results are discarded, while a strictly older taken branch can still override the active redirect.

## Interface
Parameters:
- NUM_PORTS, 2, number of ALU branch result ports
- FLUSH_CYCLES, 3, cycles the flush window stays open after the last redirect (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- en  in  1  global enable; low freezes all state
- IN_valid  in  [NUM_PORTS]  result valid per port
- IN_isBranch  in  [NUM_PORTS]  result is a branch/jump
- IN_branchTaken  in  [NUM_PORTS]  branch taken (redirect needed)
- IN_branchAddress  in  [NUM_PORTS]×32  taken target
- IN_branchSqN  in  [NUM_PORTS]×6  sqN of branch
- IN_commitSqN  in  6  sqN of oldest in-flight instruction (age base)
- OUT_redirect  out  1  one-cycle redirect pulse
- OUT_redirectAddr  out  32  redirect target
- OUT_redirectSqN  out  6  sqN of redirecting branch
- OUT_flushActive  out  1  flush window open
- OUT_flushSqN  out  6  sqN bounding current flush (results younger are void)
- OUT_statBranches  out  32  only with BRANCH_RESOLVER_STATS_EN
- OUT_statRedirects  out  32  only with BRANCH_RESOLVER_STATS_EN

## Operation
- Age: age(x) = (x − IN_commitSqN) mod 64, 6-bit unsigned; smaller = older. a older than b iff age(a) < age(b).
- Candidate on port i: IN_valid[i] && IN_isBranch[i] && IN_branchTaken[i] && (state IDLE || age(IN_branchSqN[i]) < age(OUT_flushSqN)).
- Select oldest candidate; equal ages → lowest port index.
- States: IDLE, FLUSH. Counter cnt, width $clog2(FLUSH_CYCLES+1).
- IDLE + candidate → FLUSH, cnt=FLUSH_CYCLES, redirect issued.
- FLUSH + candidate (strictly older) → stay FLUSH, cnt reloaded, redirect issued, flushSqN updated.
- FLUSH, no candidate → cnt−1; on cnt reaching 0 → IDLE (FLUSH lasts exactly FLUSH_CYCLES cycles after last redirect).
- Result with sqN equal to or younger than flushSqN during FLUSH: dropped, no effect.
- Not-taken branches never redirect.

## Timing
- Inputs sampled at edge t; OUT_redirect/Addr/SqN valid in cycle t+1; OUT_redirect high exactly one cycle per selection.
- OUT_flushActive = (state == FLUSH), registered; rises same cycle as first OUT_redirect.
- OUT_redirectAddr/SqN and OUT_flushSqN hold last values when no redirect.
- en low: no state change, inputs ignored, OUT_redirect driven 0 next cycle; other outputs hold.
- rst: state IDLE, cnt 0, all outputs 0 (including stats). Reset mid-flush aborts flush immediately.
- rst has priority over en.

## Configuration
- BRANCH_RESOLVER_STATS_EN defined: OUT_statBranches += popcount(IN_valid & IN_isBranch) per enabled cycle (including dropped); OUT_statRedirects += 1 per issued redirect; both wrap mod 2^32.
- Undefined: stat ports and counters absent.

## Structure
- Shared package: SqN type (6-bit), FLUSH state enum, age-compare function.
- One sub-module: branch_select_oldest (combinational oldest-of-N with port-index tie break), used once.

## Test plan
- Single taken branch port0, sqN 5, addr 0x1000, commit 0 → t+1 redirect=1, addr 0x1000, sqN 5; flushActive for 3 cycles, then IDLE.
- Same cycle port0 sqN 9, port1 sqN 4, commit 2, both taken → redirect sqN 4, port1 address.
- Wrap: commit 60, port0 sqN 2, port1 sqN 62 → sqN 62 selected (age 2 vs 6).
- During FLUSH (flushSqN 10, commit 0): sqN 12 taken dropped (no pulse); sqN 7 taken → redirect sqN 7, cnt reloaded to 3.
- en low for 2 cycles with taken branch present → no redirect, cnt frozen; rst during FLUSH → all outputs 0 next cycle.
- Stats build: 2 ports branch-valid 3 cycles, 1 redirect → statBranches 6, statRedirects 1.
